// File: rtl/data_ram_pkg.sv
// Shared constants for the data RAM: load funct3 codes, widths and reset/idle values.
package data_ram_pkg;

   localparam int DATA_WIDTH      = 32;
   localparam int RV32_ADDR_WIDTH = 32;

   localparam logic [2:0] INST_LB  = 3'b000;
   localparam logic [2:0] INST_LH  = 3'b001;
   localparam logic [2:0] INST_LW  = 3'b010;
   localparam logic [2:0] INST_LBU = 3'b100;
   localparam logic [2:0] INST_LHU = 3'b101;

   localparam logic [DATA_WIDTH-1:0] RST_DATA       = '0;
   localparam logic [3:0]            RAM_WR_DISABLE = 4'b0000;

endpackage

// File: rtl/data_ram_load_align.sv
// load_align: combinational load formatter (byte/half/word select, extension, misalign).
module load_align
   import data_ram_pkg::*;
(
   input  logic [DATA_WIDTH-1:0] word_i,
   input  logic [1:0]            offset_i,
   input  logic [2:0]            funct3_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  misalign_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel   = word_i[{offset_i, 3'b000} +: 8];
      half_sel   = offset_i[1] ? word_i[31:16] : word_i[15:0];
      data_o     = RST_DATA;
      misalign_o = 1'b0;
      case (funct3_i)
         INST_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
         INST_LBU: data_o = {24'h0, byte_sel};
         INST_LH:  if (offset_i[0]) misalign_o = 1'b1;
                   else             data_o = {{16{half_sel[15]}}, half_sel};
         INST_LHU: if (offset_i[0]) misalign_o = 1'b1;
                   else             data_o = {16'h0, half_sel};
         INST_LW:  if (offset_i != 2'b00) misalign_o = 1'b1;
                   else                   data_o = word_i;
         default: ;
      endcase
   end

endmodule

// File: rtl/data_ram.sv
// data_ram: byte-strobed data memory with a 1-cycle formatted load path.
// Define DATA_RAM_BYPASS_EN for write-first forwarding on same-word read/write.
module data_ram
   import data_ram_pkg::*;
#(
   parameter int DEPTH_WORDS = 4096,
   parameter int ADDR_LSB    = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ram_rd_en_i,
   input  logic [RV32_ADDR_WIDTH-1:0] ram_rd_addr_i,
   input  logic [2:0]                 ld_funct3_i,
   input  logic [3:0]                 ram_wr_en_i,
   input  logic [RV32_ADDR_WIDTH-1:0] ram_wr_addr_i,
   input  logic [DATA_WIDTH-1:0]      ram_wr_data_i,
   output logic [DATA_WIDTH-1:0]      ram_rd_data_o,
   output logic                       rd_valid_o,
   output logic                       misalign_o
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];
   logic [IDX_W-1:0]      wr_idx, rd_idx;
   logic [DATA_WIDTH-1:0] rd_word_d, rd_word_q;
   logic [1:0]            off_q;
   logic [2:0]            f3_q;
   logic                  vld_q;
   logic                  unused_addr_bits;

   assign wr_idx = ram_wr_addr_i[ADDR_LSB+IDX_W-1:ADDR_LSB];
   assign rd_idx = ram_rd_addr_i[ADDR_LSB+IDX_W-1:ADDR_LSB];

   // Bits above the word index are dropped, so addresses wrap modulo the array.
   assign unused_addr_bits = ^{ram_rd_addr_i[RV32_ADDR_WIDTH-1:ADDR_LSB+IDX_W],
                               ram_wr_addr_i[RV32_ADDR_WIDTH-1:ADDR_LSB+IDX_W],
                               ram_wr_addr_i[ADDR_LSB-1:0]};

   // Array is intentionally not reset.
   always_ff @(posedge clk) begin
      if (ram_wr_en_i != RAM_WR_DISABLE) begin
         for (int n = 0; n < 4; n++) begin
            if (ram_wr_en_i[n]) mem_q[wr_idx][8*n +: 8] <= ram_wr_data_i[8*n +: 8];
         end
      end
   end

   always_comb begin
      rd_word_d = mem_q[rd_idx];
`ifdef DATA_RAM_BYPASS_EN
      if (wr_idx == rd_idx) begin
         for (int n = 0; n < 4; n++) begin
            if (ram_wr_en_i[n]) rd_word_d[8*n +: 8] = ram_wr_data_i[8*n +: 8];
         end
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q     <= 1'b0;
         rd_word_q <= RST_DATA;
         off_q     <= 2'b00;
         f3_q      <= INST_LB;
      end else begin
         vld_q <= ram_rd_en_i;
         if (ram_rd_en_i) begin
            rd_word_q <= rd_word_d;
            off_q     <= ram_rd_addr_i[1:0];
            f3_q      <= ld_funct3_i;
         end
      end
   end

   assign rd_valid_o = vld_q;

   load_align u_align (
      .word_i     (rd_word_q),
      .offset_i   (off_q),
      .funct3_i   (f3_q),
      .data_o     (ram_rd_data_o),
      .misalign_o (misalign_o)
   );

endmodule

// File: tb/tb_data_ram.sv
// tb_data_ram: directed vector table plus randomized traffic against a byte-array model.
module tb_data_ram;

   localparam int DEPTH = 64;
`ifdef DATA_RAM_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct {
      logic        rd;
      logic [31:0] ra;
      logic [2:0]  f3;
      logic [3:0]  we;
      logic [31:0] wa;
      logic [31:0] wd;
      logic [31:0] exp_d;
      logic        exp_m;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ram_rd_en_i = 1'b0;
   logic [31:0] ram_rd_addr_i = '0;
   logic [2:0]  ld_funct3_i = '0;
   logic [3:0]  ram_wr_en_i = '0;
   logic [31:0] ram_wr_addr_i = '0;
   logic [31:0] ram_wr_data_i = '0;
   logic [31:0] ram_rd_data_o;
   logic        rd_valid_o;
   logic        misalign_o;

   int nchk = 0;
   int nerr = 0;
   logic [31:0] last_d = '0;
   logic        last_m = 1'b0;
   logic [7:0]  mdl [DEPTH*4];
   vec_t        tbl [18];

   data_ram #(.DEPTH_WORDS(DEPTH), .ADDR_LSB(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .ram_rd_en_i   (ram_rd_en_i),
      .ram_rd_addr_i (ram_rd_addr_i),
      .ld_funct3_i   (ld_funct3_i),
      .ram_wr_en_i   (ram_wr_en_i),
      .ram_wr_addr_i (ram_wr_addr_i),
      .ram_wr_data_i (ram_wr_data_i),
      .ram_rd_data_o (ram_rd_data_o),
      .rd_valid_o    (rd_valid_o),
      .misalign_o    (misalign_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic rd, input logic [31:0] ra, input logic [2:0] f3,
                               input logic [3:0] we, input logic [31:0] wa, input logic [31:0] wd,
                               input logic [31:0] ed, input logic em);
      vec_t v;
      v.rd = rd; v.ra = ra; v.f3 = f3; v.we = we; v.wa = wa; v.wd = wd;
      v.exp_d = ed; v.exp_m = em;
      return v;
   endfunction

   // Called at a negedge; returns at the following negedge with the result visible.
   task automatic drive(input vec_t v);
      ram_rd_en_i   = v.rd;
      ram_rd_addr_i = v.ra;
      ld_funct3_i   = v.f3;
      ram_wr_en_i   = v.we;
      ram_wr_addr_i = v.wa;
      ram_wr_data_i = v.wd;
      @(posedge clk);
      @(negedge clk);
      ram_rd_en_i = 1'b0;
      ram_wr_en_i = 4'h0;
   endtask

   task automatic check_cycle(input string nm, input vec_t v);
      if (v.rd) begin
         last_d = v.exp_d;
         last_m = v.exp_m;
      end
      chk({nm, ".valid"}, {31'h0, rd_valid_o}, {31'h0, v.rd});
      chk({nm, ".data"}, ram_rd_data_o, last_d);
      chk({nm, ".mis"}, {31'h0, misalign_o}, {31'h0, last_m});
   endtask

   function automatic void mdl_write(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
      int base;
      base = ((a >> 2) % DEPTH) * 4;
      for (int n = 0; n < 4; n++) if (we[n]) mdl[base+n] = wd[8*n +: 8];
   endfunction

   function automatic void mdl_load(input logic [31:0] a, input logic [2:0] f3,
                                    output logic [31:0] d, output logic m);
      int base, off;
      logic [7:0]  b;
      logic [15:0] h;
      base = ((a >> 2) % DEPTH) * 4;
      off  = a % 4;
      b = mdl[base+off];
      h = {mdl[base+(off|1)], mdl[base+(off & 2)]};
      d = '0;
      m = 1'b0;
      case (f3)
         3'd0: d = int'($signed(b));
         3'd4: d = 32'(b);
         3'd1, 3'd5: if (off % 2 != 0) m = 1'b1;
                     else d = (f3 == 3'd1) ? int'($signed(h)) : 32'(h);
         3'd2: if (off != 0) m = 1'b1;
               else d = {mdl[base+3], mdl[base+2], mdl[base+1], mdl[base]};
         default: ;
      endcase
   endfunction

   initial begin
      vec_t v;
      logic [31:0] ed;
      logic        em;

      // Power-on reset, released at a negedge.
      repeat (2) @(negedge clk);
      chk("rst.valid", {31'h0, rd_valid_o}, 32'h0);
      chk("rst.data", ram_rd_data_o, 32'h0);
      chk("rst.mis", {31'h0, misalign_o}, 32'h0);
      rst = 1'b0;

      tbl[0]  = mk(0, 0,      3'd0, 4'hF, 32'h10, 32'h8000_7F81, 0, 0);
      tbl[1]  = mk(1, 32'h10, 3'd0, 4'h0, 0, 0, 32'hFFFF_FF81, 0);
      tbl[2]  = mk(1, 32'h11, 3'd4, 4'h0, 0, 0, 32'h0000_007F, 0);
      tbl[3]  = mk(1, 32'h12, 3'd1, 4'h0, 0, 0, 32'hFFFF_8000, 0);
      tbl[4]  = mk(1, 32'h10, 3'd2, 4'h0, 0, 0, 32'h8000_7F81, 0);
      tbl[5]  = mk(0, 0,      3'd0, 4'b0100, 32'h10, 32'h00AB_0000, 0, 0);
      tbl[6]  = mk(1, 32'h10, 3'd2, 4'h0, 0, 0, 32'h80AB_7F81, 0);
      tbl[7]  = mk(1, 32'h13, 3'd1, 4'h0, 0, 0, 32'h0, 1);
      tbl[8]  = mk(1, 32'h12, 3'd2, 4'h0, 0, 0, 32'h0, 1);
      tbl[9]  = mk(1, 32'h13, 3'd0, 4'h0, 0, 0, 32'hFFFF_FF80, 0);
      tbl[10] = mk(0, 0,      3'd0, 4'hF, 32'h20, 32'h1111_1111, 0, 0);
      tbl[11] = mk(1, 32'h20, 3'd2, 4'b0001, 32'h20, 32'h0000_00FF,
                   BYP ? 32'h1111_11FF : 32'h1111_1111, 0);
      tbl[12] = mk(1, 32'h20, 3'd2, 4'h0, 0, 0, 32'h1111_11FF, 0);
      tbl[13] = mk(0, 0,      3'd0, 4'hF, DEPTH*4 + 32'h4, 32'hCAFE_F00D, 0, 0);
      tbl[14] = mk(1, 32'h4,  3'd2, 4'h0, 0, 0, 32'hCAFE_F00D, 0);
      tbl[15] = mk(1, 32'h10, 3'd3, 4'h0, 0, 0, 32'h0, 0);
      tbl[16] = mk(1, 32'h12, 3'd5, 4'h0, 0, 0, 32'h0000_80AB, 0);
      tbl[17] = mk(0, 0,      3'd0, 4'h0, 0, 0, 0, 0);

      for (int i = 0; i < 18; i++) begin
         drive(tbl[i]);
         check_cycle($sformatf("vec%0d", i), tbl[i]);
      end

      // Reset asserted mid-cycle while a result is pending: it must be dropped.
      ram_rd_en_i = 1'b1; ram_rd_addr_i = 32'h10; ld_funct3_i = 3'd2;
      @(posedge clk);
      #2 rst = 1'b1;
      ram_rd_en_i = 1'b0;
      #1;
      chk("midrst.valid", {31'h0, rd_valid_o}, 32'h0);
      chk("midrst.data", ram_rd_data_o, 32'h0);
      chk("midrst.mis", {31'h0, misalign_o}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("postrst.valid", {31'h0, rd_valid_o}, 32'h0);
      chk("postrst.data", ram_rd_data_o, 32'h0);
      last_d = '0;
      last_m = 1'b0;

      // Known contents for words 0..15, then random mixed traffic.
      for (int w = 0; w < 16; w++) begin
         v = mk(0, 0, 3'd0, 4'hF, w * 4, $urandom, 0, 0);
         mdl_write(v.wa, v.we, v.wd);
         drive(v);
         check_cycle("init", v);
      end
      for (int i = 0; i < 400; i++) begin
         v.rd = 1'($urandom);
         v.ra = $urandom & 32'hFFFF_FF3F;
         v.f3 = 3'($urandom);
         v.we = 4'($urandom);
         v.wa = $urandom & 32'hFFFF_FF3F;
         v.wd = $urandom;
         if (BYP) mdl_write(v.wa, v.we, v.wd);
         mdl_load(v.ra, v.f3, ed, em);
         if (!BYP) mdl_write(v.wa, v.we, v.wd);
         v.exp_d = ed;
         v.exp_m = em;
         drive(v);
         check_cycle($sformatf("rnd%0d", i), v);
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
